// File: rtl/r4b_deser_if.sv
// r4b_deser_if: serial-link receive side and word-output handshake bundle.
// Ports (via modports):
//   slave  (receiver): in  start, sh, sh_in, q_ready; out q, q_valid, busy, ovf
//   master (driver)  : out start, sh, sh_in, q_ready; in  q, q_valid, busy, ovf
interface r4b_deser_if #(parameter int W = 4);
  logic start;
  logic sh;
  logic sh_in;
  logic q_ready;
  logic [W-1:0] q;
  logic q_valid;
  logic busy;
  logic ovf;
  modport slave (input start, sh, sh_in, q_ready, output q, q_valid, busy, ovf);
  modport master (output start, sh, sh_in, q_ready, input q, q_valid, busy, ovf);
endinterface

// File: rtl/r4b_deser.sv
// r4b_deser: LSB-first serial-to-parallel receiver with a valid/ready output holding register.
// Ports: clk (rising edge), rst_b (async, active-low),
//   bus.slave: start/sh/sh_in serial input, q_ready consumer accept,
//              q/q_valid held word, busy partial frame in progress, ovf sticky overrun.
module r4b_deser #(parameter int W = 4) (
  input logic clk,
  input logic rst_b,
  r4b_deser_if.slave bus
);
  localparam int CW = $clog2(W);
  logic [W-1:0] sr, w;
  logic [CW-1:0] cnt;
  logic last, done, take;
  always_comb begin
    w = {bus.sh_in, sr[W-1:1]};
    last = cnt == CW'(W - 1);
    done = bus.sh && !bus.start && last;
    // the holding register can take the word if empty or being drained this cycle
    take = done && (!bus.q_valid || bus.q_ready);
  end
  assign bus.busy = cnt != '0;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sr <= '0;
      cnt <= '0;
      bus.q <= '0;
      bus.q_valid <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      // start wins over frame completion, so a partial frame is never emitted
      if (bus.start) begin
        sr <= bus.sh ? {bus.sh_in, {(W-1){1'b0}}} : '0;
        cnt <= bus.sh ? CW'(1) : '0;
      end else if (bus.sh) begin
        sr <= last ? '0 : w;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (take) bus.q <= w;
      bus.q_valid <= take || (bus.q_valid && !bus.q_ready);
      bus.ovf <= !bus.start && (bus.ovf || (done && !take));
    end
  end
endmodule

// File: tb/tb_r4b_deser.sv
// tb_r4b_deser: directed scoreboard bench for r4b_deser (W=4).
module tb_r4b_deser;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_w = 4'b0000;
  r4b_deser_if #(.W(4)) bus ();
  r4b_deser #(.W(4)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic check_word(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s_sb: observed word %0h but scoreboard empty", tag, bus.q);
    end else begin
      e = exp_q.pop_front();
      last_w = e;
      chk({tag, "_q"}, 32'(bus.q), 32'(e));
      chk({tag, "_v"}, 32'(bus.q_valid), 32'd1);
    end
  endtask
  task automatic frame(input string tag, input logic [3:0] w, input int gap, input logic rdy);
    for (int i = 0; i < 4; i++) begin
      bus.sh = 1'b1;
      bus.sh_in = w[i];
      bus.q_ready = (i == 3) ? rdy : 1'b0;
      tick();
      bus.sh = 1'b0;
      bus.q_ready = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) begin
        repeat (gap) tick();
        if (gap > 0) chk({tag, "_busy_gap"}, 32'(bus.busy), 32'd1);
      end
    end
  endtask
  task automatic drain(input string tag);
    bus.q_ready = 1'b1;
    tick();
    bus.q_ready = 1'b0;
    chk({tag, "_drain_v"}, 32'(bus.q_valid), 32'd0);
    chk({tag, "_drain_q"}, 32'(bus.q), 32'(last_w));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.sh = 1'b0;
    bus.sh_in = 1'b0;
    bus.q_ready = 1'b0;
    tick();
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_v", 32'(bus.q_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_b = 1'b1;
    tick();
    bus.q_ready = 1'b1;
    tick();
    bus.q_ready = 1'b0;
    chk("idle_ready_v", 32'(bus.q_valid), 32'd0);
    // basic frame: bits 1,0,1,1 -> 1101
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_q.push_back(4'b1101);
    frame("basic", 4'b1101, 0, 1'b0);
    check_word("basic");
    chk("basic_ovf", 32'(bus.ovf), 32'd0);
    tick();
    chk("basic_hold_q", 32'(bus.q), 32'hd);
    drain("basic");
    // gapped frame: bits 0,1,1,0 with two idle cycles between -> 0110
    exp_q.push_back(4'b0110);
    frame("gap", 4'b0110, 2, 1'b0);
    check_word("gap");
    drain("gap");
    // back-to-back: 1101 pending, then 1111 with q_ready on the last bit
    exp_q.push_back(4'b1101);
    frame("b2b1", 4'b1101, 0, 1'b0);
    check_word("b2b1");
    exp_q.push_back(4'b1111);
    frame("b2b2", 4'b1111, 1, 1'b1);
    check_word("b2b2");
    chk("b2b_ovf", 32'(bus.ovf), 32'd0);
    drain("b2b");
    // overrun: 1101 pending, 1000 arrives with q_ready low -> dropped
    exp_q.push_back(4'b1101);
    frame("ovr1", 4'b1101, 0, 1'b0);
    check_word("ovr1");
    frame("ovr2", 4'b1000, 0, 1'b0);
    chk("ovr_q", 32'(bus.q), 32'hd);
    chk("ovr_v", 32'(bus.q_valid), 32'd1);
    chk("ovr_ovf", 32'(bus.ovf), 32'd1);
    tick();
    chk("ovr_sticky", 32'(bus.ovf), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_ovf", 32'(bus.ovf), 32'd0);
    chk("start_q", 32'(bus.q), 32'hd);
    chk("start_v", 32'(bus.q_valid), 32'd1);
    drain("ovr");
    // abort: bits 1,1 then start with sh (bit 0) followed by 1,0,1 -> 1010
    for (int i = 0; i < 2; i++) begin
      bus.sh = 1'b1;
      bus.sh_in = 1'b1;
      tick();
    end
    bus.sh = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.sh = 1'b1;
    bus.sh_in = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.sh = 1'b0;
    chk("abort_busy1", 32'(bus.busy), 32'd1);
    exp_q.push_back(4'b1010);
    for (int i = 1; i < 4; i++) begin
      bus.sh = 1'b1;
      bus.sh_in = (i != 2);
      tick();
    end
    bus.sh = 1'b0;
    check_word("abort");
    chk("abort_busy_end", 32'(bus.busy), 32'd0);
    // overrun again, then partial frame, then asynchronous reset mid-cycle
    frame("ovr3", 4'b0101, 0, 1'b0);
    chk("ovr3_ovf", 32'(bus.ovf), 32'd1);
    chk("ovr3_q", 32'(bus.q), 32'ha);
    bus.sh = 1'b1;
    bus.sh_in = 1'b1;
    tick();
    bus.sh = 1'b0;
    chk("pre_arst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_q", 32'(bus.q), 32'd0);
    chk("arst_v", 32'(bus.q_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ovf", 32'(bus.ovf), 32'd0);
    tick();
    rst_b = 1'b1;
    tick();
    exp_q.push_back(4'b0011);
    frame("post_rst", 4'b0011, 0, 1'b0);
    check_word("post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
